// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the PLL lock controller and its environment.
// The controller connects through the slave modport; the driver of lock/restart uses master.
`timescale 1ns/1ps

interface pll_lock_ctrl_if;
    logic       pll_lock_i;
    logic       restart_i;
    logic       pll_pwrdn_n_o;
    logic       sys_rst_o;
    logic       locked_o;
    logic       fail_o;
    logic [3:0] retry_cnt_o;

    modport master (
        output pll_lock_i, restart_i,
        input  pll_pwrdn_n_o, sys_rst_o, locked_o, fail_o, retry_cnt_o
    );

    modport slave (
        input  pll_lock_i, restart_i,
        output pll_pwrdn_n_o, sys_rst_o, locked_o, fail_o, retry_cnt_o
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL power-up sequencer: power-down pulse, lock wait, stability filter, then system reset release.
// Define PLL_LOCK_CTRL_AUTO_RETRY_EN to retry failed attempts up to MAX_RETRIES times before FAIL.
`timescale 1ns/1ps

module pll_lock_ctrl #(
    parameter int unsigned PWRDN_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input logic           clk_i,
    input logic           rst_i,
    pll_lock_ctrl_if.slave bus
);

    localparam logic [2:0] S_PWRDN     = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam logic [16:0] C_PWRDN_LAST   = 17'(PWRDN_CYCLES - 1);
    localparam logic [16:0] C_TIMEOUT_LAST = 17'(LOCK_TIMEOUT - 1);
    localparam logic [16:0] C_STABLE_LAST  = 17'(STABLE_CYCLES - 1);

    logic [1:0]  r_sync;
    logic [2:0]  r_state;
    logic [16:0] r_cnt;
    logic [2:0]  w_next_state;
    logic        w_lock_s;
    logic        w_restart;
    logic        w_fail_evt;
    logic        w_retry_ok;

    // pll_lock_i is asynchronous; nothing else may look at it before these two flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments keep the two stages one cycle apart; blocking would collapse them.
            r_sync <= {r_sync[0], bus.pll_lock_i};
        end
    end

    assign w_lock_s  = r_sync[1];
    assign w_restart = bus.restart_i && (r_state != S_PWRDN);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_next_state = r_state;
        w_fail_evt   = 1'b0;
        if (w_restart) begin
            w_next_state = S_PWRDN;
        end else begin
            case (r_state)
                S_PWRDN: begin
                    if (r_cnt == C_PWRDN_LAST) w_next_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s)                        w_next_state = S_STABLE;
                    else if (r_cnt == C_TIMEOUT_LAST)    w_fail_evt   = 1'b1;
                end
                S_STABLE: begin
                    if (!w_lock_s)                       w_next_state = S_WAIT_LOCK;
                    else if (r_cnt == C_STABLE_LAST)     w_next_state = S_RUN;
                end
                S_RUN: begin
                    if (!w_lock_s) w_fail_evt = 1'b1;
                end
                S_FAIL:  w_next_state = S_FAIL;
                default: w_next_state = S_PWRDN;
            endcase
            if (w_fail_evt) w_next_state = w_retry_ok ? S_PWRDN : S_FAIL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_PWRDN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter restarts on any state change and saturates rather than wrapping.
            if (w_next_state != r_state) r_cnt <= '0;
            else if (r_cnt != '1)        r_cnt <= r_cnt + 17'd1;
        end
    end

`ifdef PLL_LOCK_CTRL_AUTO_RETRY_EN
    logic [3:0] r_retry;

    assign w_retry_ok = (r_retry < 4'(MAX_RETRIES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retry <= 4'd0;
        end else if (w_restart) begin
            r_retry <= 4'd0;
        end else if (w_fail_evt && w_retry_ok) begin
            r_retry <= r_retry + 4'd1;
        end
    end

    assign bus.retry_cnt_o = r_retry;
`else
    assign w_retry_ok      = 1'b0;
    assign bus.retry_cnt_o = 4'd0;
`endif

    // Moore outputs: decoded from the registered state only, so reset reaches them asynchronously.
    assign bus.pll_pwrdn_n_o = !((r_state == S_PWRDN) || (r_state == S_FAIL));
    assign bus.sys_rst_o     = (r_state != S_RUN);
    assign bus.locked_o      = (r_state == S_RUN);
    assign bus.fail_o        = (r_state == S_FAIL);

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with short timing parameters; expectations follow the
// PLL_LOCK_CTRL_AUTO_RETRY_EN setting used for the build.
`timescale 1ns/1ps

module tb_pll_lock_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(
        .PWRDN_CYCLES (16),
        .LOCK_TIMEOUT (64),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic pwrdn_n, input logic sys_rst,
                             input logic locked, input logic fail, input logic [3:0] retry);
        check({tag, ".pwrdn_n"}, {3'b000, bus.pll_pwrdn_n_o}, {3'b000, pwrdn_n});
        check({tag, ".sys_rst"}, {3'b000, bus.sys_rst_o},     {3'b000, sys_rst});
        check({tag, ".locked"},  {3'b000, bus.locked_o},      {3'b000, locked});
        check({tag, ".fail"},    {3'b000, bus.fail_o},        {3'b000, fail});
        check({tag, ".retry"},   bus.retry_cnt_o,             retry);
    endtask

    // Advance to just after rising edge number e (sampled on the following falling edge).
    task automatic goto_edge(input int e);
        while (edge_n < e) begin
            @(negedge clk_i);
            edge_n++;
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        bus.pll_lock_i = 1'b1;
        bus.restart_i  = 1'b0;

        // Reset values appear asynchronously, before any clock edge.
        #1 rst_i = 1'b1;
        #1 check_out("reset_async", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk_i);
        apply_reset();

        // Lock tied high: power-down ends at edge 16, RUN at edge 25.
        goto_edge(15); check_out("up_e15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(16); check_out("up_e16", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(24); check_out("up_e24", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(25); check_out("up_e25", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Lock glitch in STABLE (raw low at edges 19..21): back to WAIT_LOCK, STABLE again at 24, RUN at 32.
        apply_reset();
        goto_edge(18);
        bus.pll_lock_i = 1'b0;
        goto_edge(21);
        bus.pll_lock_i = 1'b1;
        goto_edge(25); check_out("glitch_e25", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(31); check_out("glitch_e31", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(32); check_out("glitch_e32", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Lock loss in RUN: outputs react on the third edge after the drop.
        goto_edge(33);
        bus.pll_lock_i = 1'b0;
        goto_edge(35); check_out("runloss_p2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        goto_edge(36);
`ifdef PLL_LOCK_CTRL_AUTO_RETRY_EN
        check_out("runloss_p3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
`else
        check_out("runloss_p3", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
`endif

        // Lock never arrives: timeout at edge 80, then retries or FAIL.
        apply_reset();
        goto_edge(79); check_out("nolock_e79", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(80);
`ifdef PLL_LOCK_CTRL_AUTO_RETRY_EN
        check_out("nolock_e80",  1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        goto_edge(95);  check_out("nolock_e95",  1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        goto_edge(96);  check_out("nolock_e96",  1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        goto_edge(160); check_out("nolock_e160", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        goto_edge(240); check_out("nolock_e240", 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        goto_edge(319); check_out("nolock_e319", 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        goto_edge(320); check_out("nolock_e320", 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
`else
        check_out("nolock_e80", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        goto_edge(100); check_out("nolock_e100", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
`endif

        // Restart from FAIL: back to PWRDN with the retry count cleared.
        bus.restart_i = 1'b1;
        @(negedge clk_i);
        bus.restart_i  = 1'b0;
        bus.pll_lock_i = 1'b1;
        edge_n = 0;
        check_out("restart_fail", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Restart while in PWRDN is ignored: power-down still ends at edge 16.
        goto_edge(5);
        bus.restart_i = 1'b1;
        goto_edge(6);
        bus.restart_i = 1'b0;
        goto_edge(15); check_out("restart_pwrdn_e15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        goto_edge(16); check_out("restart_pwrdn_e16", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of STABLE, between clock edges.
        goto_edge(18);
        #2 rst_i = 1'b1;
        #1 check_out("async_rst_stable", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk_i);
        rst_i  = 1'b0;
        edge_n = 0;
        goto_edge(25); check_out("after_async_rst_e25", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter PWRDN_CYCLES, default 16: cycles the PLL is held powered down per start attempt (>=2).
REQ-002 Parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before an attempt fails (>=2).
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release (>=2).
REQ-004 Parameter MAX_RETRIES, default 3: automatic restart attempts before FAIL (1..15).
REQ-005 clk_i  in  1  crystal reference clock (same clock feeding the PLL CLKA input; never a PLL output).
REQ-006 rst_i  in  1  asynchronous reset, active high.
REQ-007 pll_lock_i  in  1  PLL LOCK, asynchronous to clk_i.
REQ-008 restart_i  in  1  single-cycle request to power-cycle the PLL and restart the sequence.
REQ-009 pll_pwrdn_n_o  out  1  drives the PLL POWERDOWN pin; 0 = PLL powered down.
REQ-010 sys_rst_o  out  1  active-high system reset for all logic on PLL output clocks.
REQ-011 locked_o  out  1  high only in RUN.
REQ-012 fail_o  out  1  high only in FAIL.
REQ-013 retry_cnt_o  out  4  automatic retries consumed since the last rst_i/restart_i.

Function
REQ-014 pll_lock_i SHALL pass through a 2-flop synchronizer (lock_s) before any use; no other path from pll_lock_i.
REQ-015 State machine SHALL have states PWRDN, WAIT_LOCK, STABLE, RUN, FAIL, plus one 17-bit cycle counter cnt zeroed on every state change.
REQ-016 PWRDN: cnt increments; at cnt==PWRDN_CYCLES-1 the SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK: lock_s=1 -> STABLE; else at cnt==LOCK_TIMEOUT-1 -> failure handling (REQ-021).
REQ-018 STABLE: lock_s=0 -> WAIT_LOCK (not a retry, timeout restarts); else at cnt==STABLE_CYCLES-1 -> RUN.
REQ-019 RUN: lock_s=0 -> failure handling (REQ-021); otherwise stays.
REQ-020 FAIL: stays until restart_i or rst_i.
REQ-021 Failure handling defined under Configuration.
REQ-022 restart_i=1 in any state except PWRDN SHALL go to PWRDN and clear retry_cnt_o; ignored in PWRDN; takes priority over every other transition in the same cycle.
REQ-023 Outputs SHALL be Moore, decoded from registered state: pll_pwrdn_n_o=0 in PWRDN and FAIL, else 1; sys_rst_o=0 only in RUN; locked_o=1 only in RUN; fail_o=1 only in FAIL.
REQ-024 retry_cnt_o SHALL increment by 1 per automatic retry, never wrap, and is not cleared on reaching RUN.
REQ-025 Counters SHALL never wrap; cnt compare is exact equality.

Reset
REQ-026 rst_i=1 SHALL immediately force state PWRDN, cnt=0, synchronizer=0, retry_cnt_o=0, pll_pwrdn_n_o=0, sys_rst_o=1, locked_o=0, fail_o=0, including mid-sequence.
REQ-027 rst_i deassertion SHALL be taken synchronously; first rising edge with rst_i low is edge 1.

Configuration
REQ-028 Macro PLL_LOCK_CTRL_AUTO_RETRY_EN defined: failure handling goes to PWRDN with retry_cnt_o+1 if retry_cnt_o<MAX_RETRIES, else FAIL.
REQ-029 Macro undefined: failure handling always goes to FAIL; retry_cnt_o is constant 0.

Verification (PWRDN_CYCLES=16, LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRIES=3)
REQ-030 pll_lock_i tied 1 from reset -> pll_pwrdn_n_o rises after edge 16, STABLE after edge 17, sys_rst_o=0 and locked_o=1 after edge 25.
REQ-031 Lock drops for 3 cycles during STABLE -> back to WAIT_LOCK, retry_cnt_o stays 0, sys_rst_o held 1, RUN reached 8 cycles after lock_s returns.
REQ-032 pll_lock_i held 0, macro defined -> 3 retries (retry_cnt_o 1,2,3, each with 16-cycle pwrdn_n=0 pulse), then FAIL with fail_o=1, pll_pwrdn_n_o=0; macro undefined -> FAIL after first 64-cycle timeout.
REQ-033 In RUN, lock drops -> sys_rst_o=1 and locked_o=0 3 edges after the drop (2 sync + 1 state); macro defined: PWRDN entered, retry_cnt_o=1.
REQ-034 restart_i pulse in FAIL -> PWRDN, retry_cnt_o=0, fail_o=0; restart_i pulse in PWRDN -> no effect, cnt not reset.
REQ-035 rst_i asserted mid-STABLE asynchronously (between edges) -> all outputs at reset values before the next edge.
